crc_req_scheduler: RTL and testbench

- Shares one parallel CRC-5 engine (4-bit nibble in, 5-bit CRC out) between `NREQ` requesters on a frame-by-frame basis.
- Arbitration is round-robin. The granted requester streams its frame through the block to the engine, and the block returns the finished CRC tagged with the requester index.
- The block sits between the requester-side nibble streams and the engine's `data_in`/`data_out` port pair.

---
 rtl/crc_req_scheduler_pkg.sv | 25 ++
 rtl/crc_req_scheduler_if.sv | 33 +++
 rtl/crc_req_scheduler_rr_arbiter.sv | 17 +
 rtl/crc_req_scheduler.sv | 83 ++++++++
 tb/tb_crc_req_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_req_scheduler_pkg.sv
// crc_sched_pkg: FSM state type, width defaults and round-robin pick helper for crc_req_scheduler
package crc_sched_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, RESULT} sched_state_t;
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;
    localparam int MAX_NREQ = 8;
    localparam int DW_DEF   = 4;
    localparam int CW_DEF   = 5;
    // Scan downward so the last hit kept is the nearest one at or after ptr.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req, input logic [2:0] ptr, input int n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (k < n && req[3'(j)]) begin
                p.found = 1'b1;
                p.idx   = 3'(j);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/crc_req_scheduler_if.sv
// crc_req_scheduler_if: requester streams, engine port pair and tagged result of the CRC scheduler
interface crc_req_scheduler_if
    import crc_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = DW_DEF,
    parameter int CW        = CW_DEF,
    parameter int MAX_BEATS = 64
);
    localparam int IW = $clog2(NREQ);
    localparam int LW = $clog2(MAX_BEATS + 1);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               crc_clr;
    logic               crc_en;
    logic [DW-1:0]      data_in;
    logic [CW-1:0]      data_out;
    logic               res_valid;
    logic [IW-1:0]      res_id;
    logic [CW-1:0]      res_crc;
    logic [LW-1:0]      res_len;
    logic               res_err;
    modport master (
        output req_valid, req_data, req_last, data_out,
        input  req_ready, crc_clr, crc_en, data_in, res_valid, res_id, res_crc, res_len, res_err
    );
    modport slave (
        input  req_valid, req_data, req_last, data_out,
        output req_ready, crc_clr, crc_en, data_in, res_valid, res_id, res_crc, res_len, res_err
    );
endinterface

// File: rtl/crc_req_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
    import crc_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);
    pick_t pick;
    assign pick    = rr_pick(MAX_NREQ'(req), 3'(ptr), NREQ);
    assign gnt_idx = IW'(pick.idx);
    assign gnt_any = pick.found;
endmodule

// File: rtl/crc_req_scheduler.sv
// crc_req_scheduler: frame-by-frame round-robin sharing of one CRC-5 nibble engine among NREQ requesters
module crc_req_scheduler
    import crc_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = DW_DEF,
    parameter int CW        = CW_DEF,
    parameter int MAX_BEATS = 64
) (
    input logic                clk,
    input logic                rst,
    crc_req_scheduler_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int LW = $clog2(MAX_BEATS + 1);
    sched_state_t  state;
    logic [IW-1:0] gnt, rr_ptr, pick_idx;
    logic          pick_any, accept, last, full;
    logic [LW-1:0] cnt, cnt_inc;
    logic          err;
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );
    assign accept        = state == STREAM && bus.req_valid[gnt];
    assign last          = bus.req_last[gnt];
    assign cnt_inc       = cnt + 1'b1;
    assign full          = cnt_inc == LW'(MAX_BEATS);
    assign bus.req_ready = state == STREAM ? NREQ'(1) << gnt : '0;
    assign bus.crc_en    = accept;
    assign bus.data_in   = accept ? DW'(bus.req_data >> (DW * gnt)) : '0;
    // crc_clr and res_valid are raised on the transition into CLEAR/RESULT so they stay registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gnt           <= '0;
            rr_ptr        <= '0;
            cnt           <= '0;
            err           <= 1'b0;
            bus.crc_clr   <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_crc   <= '0;
            bus.res_len   <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            bus.crc_clr   <= 1'b0;
            bus.res_valid <= 1'b0;
            case (state)
                IDLE: if (pick_any) begin
                    gnt         <= pick_idx;
                    bus.crc_clr <= 1'b1;
                    state       <= CLEAR;
                end
                CLEAR: begin
                    cnt   <= '0;
                    err   <= 1'b0;
                    state <= STREAM;
                end
                STREAM: if (accept) begin
                    cnt <= cnt_inc;
                    if (!last && full) err <= 1'b1;
                    if (last || full) state <= WAIT;
                end
                WAIT: begin
                    bus.res_valid <= 1'b1;
                    bus.res_id    <= gnt;
                    bus.res_crc   <= CW'(bus.data_out);
                    bus.res_len   <= cnt;
                    bus.res_err   <= err;
                    state         <= RESULT;
                end
                RESULT: begin
                    rr_ptr <= gnt == IW'(NREQ - 1) ? '0 : gnt + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_req_scheduler.sv
// tb_crc_req_scheduler: directed bench with requester models, a CRC-5 engine model and a result scoreboard
module tb_crc_req_scheduler;
    localparam int NREQ = 4, DW = 4, CW = 5, MAX_BEATS = 64;
    typedef struct { logic [3:0] nib; logic last; int gap; } beat_t;
    typedef struct { int id; logic [4:0] crc; int len; logic err; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0, errors = 0, cyc = 0, res_seen = 0, clr_cnt = 0;
    beat_t rq[NREQ][$];
    exp_t exp_q[$];
    logic [3:0] fr[$];
    logic [3:0] en_log[$];
    int res_cyc[$];
    logic [4:0] eng;

    crc_req_scheduler_if #(.NREQ(NREQ), .DW(DW), .CW(CW), .MAX_BEATS(MAX_BEATS)) bus ();
    crc_req_scheduler #(.NREQ(NREQ), .DW(DW), .CW(CW), .MAX_BEATS(MAX_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // CRC-5 engine, polynomial x^5+x^2+1, MSB of each nibble first, seed 0
    function automatic logic [4:0] crc5_nib(input logic [4:0] c, input logic [3:0] d);
        logic [4:0] x;
        logic fb;
        x = c;
        for (int b = 3; b >= 0; b--) begin
            fb = x[4] ^ ((d >> b) & 4'h1) != 0;
            x  = {x[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return x;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) eng <= bus.crc_clr ? 5'd0 : bus.crc_en ? crc5_nib(eng, bus.data_in) : eng;
    assign bus.data_out = eng;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] crc_of(input int lo, input int hi);
        logic [4:0] c;
        c = '0;
        for (int i = lo; i <= hi; i++) c = crc5_nib(c, fr[i]);
        return c;
    endfunction

    task automatic frame_hex(input logic [31:0] v, input int n);
        fr.delete();
        for (int i = n - 1; i >= 0; i--) fr.push_back(4'(v >> (4 * i)));
    endtask

    task automatic load_frame(input int r, input int gap_at, input int gap_len);
        beat_t b;
        for (int i = 0; i < fr.size(); i++) begin
            b.nib  = fr[i];
            b.last = (i == fr.size() - 1);
            b.gap  = (i == gap_at) ? gap_len : 0;
            rq[r].push_back(b);
        end
    endtask

    task automatic expect_res(input int id, input int lo, input int hi, input logic err);
        exp_t e;
        e.id  = id;
        e.crc = crc_of(lo, hi);
        e.len = hi - lo + 1;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        logic [NREQ-1:0] v, l;
        logic [NREQ*DW-1:0] d;
        beat_t b;
        v = '0;
        l = '0;
        d = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (rq[r].size() > 0) begin
                b = rq[r][0];
                if (b.gap > 0) begin
                    b.gap = b.gap - 1;
                    rq[r][0] = b;
                end else begin
                    v |= NREQ'(1) << r;
                    l |= NREQ'(b.last) << r;
                    d |= (NREQ * DW)'(b.nib) << (DW * r);
                end
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic wait_res(input string name, input int n, input int budget);
        int target;
        target = res_seen + n;
        for (int i = 0; i < budget && res_seen < target; i++) @(negedge clk);
        chk(name, res_seen >= target, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int r = 0; r < NREQ; r++) rq[r].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("exp_drained", exp_q.size(), 0);
        exp_q.delete();
        en_log.delete();
        res_cyc.delete();
        clr_cnt = 0;
    endtask

    // requester models: sample acceptance just before the edge, advance just after it
    initial begin : driver
        logic [NREQ-1:0] acc;
        drive();
        forever begin
            @(negedge clk);
            #4;
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++)
                if (((acc >> r) & 1) != 0 && rq[r].size() > 0) void'(rq[r].pop_front());
            drive();
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.crc_clr) clr_cnt++;
            if (bus.crc_en) en_log.push_back(bus.data_in);
            if (bus.res_valid) begin
                res_seen++;
                res_cyc.push_back(cyc);
                chk("res_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("res_id", bus.res_id, e.id);
                    chk("res_crc", bus.res_crc, e.crc);
                    chk("res_len", bus.res_len, e.len);
                    chk("res_err", bus.res_err, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s, n3, base;
        do_reset();
        chk("reset_outputs", {bus.req_ready, bus.crc_en, bus.data_in, bus.crc_clr, bus.res_valid,
                              bus.res_id, bus.res_crc, bus.res_len, bus.res_err}, 0);
        // single 3-nibble frame from requester 2
        @(posedge clk);
        #2;
        s = cyc;
        frame_hex(32'h123, 3);
        load_frame(2, -1, 0);
        expect_res(2, 0, 2, 1'b0);
        wait_res("t1_done", 1, 30);
        chk("t1_latency", res_cyc.size() > 0 ? res_cyc[0] - s : -1, 7);
        chk("t1_clr_pulses", clr_cnt, 1);
        chk("t1_en_count", en_log.size(), 3);
        chk("t1_en_data", en_log.size() == 3 ? {en_log[0], en_log[1], en_log[2]} : 12'h0, 12'h123);
        // all four requesters busy from reset, single-nibble frames
        do_reset();
        @(posedge clk);
        #2;
        frame_hex(32'hA, 1); load_frame(0, -1, 0); expect_res(0, 0, 0, 1'b0);
        frame_hex(32'h7, 1); load_frame(1, -1, 0); expect_res(1, 0, 0, 1'b0);
        frame_hex(32'hC, 1); load_frame(2, -1, 0); expect_res(2, 0, 0, 1'b0);
        frame_hex(32'hF, 1); load_frame(3, -1, 0); expect_res(3, 0, 0, 1'b0);
        frame_hex(32'h5, 1); load_frame(0, -1, 0); expect_res(0, 0, 0, 1'b0);
        wait_res("t2_done", 5, 60);
        if (res_cyc.size() == 5)
            for (int i = 1; i < 5; i++) chk($sformatf("t2_spacing%0d", i), res_cyc[i] - res_cyc[i-1], 5);
        // requester 1 stalls 3 cycles before its third nibble
        do_reset();
        @(posedge clk);
        #2;
        s = cyc;
        frame_hex(32'h94E2, 4);
        load_frame(1, 2, 3);
        expect_res(1, 0, 3, 1'b0);
        wait_res("t3_done", 1, 40);
        chk("t3_latency", res_cyc.size() > 0 ? res_cyc[0] - s : -1, 11);
        chk("t3_en_count", en_log.size(), 4);
        chk("t3_en_data", en_log.size() == 4 ? {en_log[0], en_log[1], en_log[2], en_log[3]} : 16'h0, 16'h94E2);
        // 70-nibble frame truncated at 64, remainder forms a second frame
        do_reset();
        @(posedge clk);
        #2;
        fr.delete();
        for (int i = 0; i < 70; i++) fr.push_back(4'(i));
        load_frame(0, -1, 0);
        expect_res(0, 0, 63, 1'b1);
        expect_res(0, 64, 69, 1'b0);
        wait_res("t4_done", 2, 200);
        chk("t4_clr_pulses", clr_cnt, 2);
        // reset during the second beat aborts the frame; it restarts cleanly
        do_reset();
        @(posedge clk);
        #2;
        frame_hex(32'h386, 3);
        load_frame(1, -1, 0);
        for (int i = 0; i < 20 && !bus.crc_en; i++) @(negedge clk);
        chk("t5_first_beat", bus.crc_en, 1);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_reset_outputs", {bus.req_ready, bus.crc_en, bus.data_in, bus.crc_clr, bus.res_valid,
                                 bus.res_id, bus.res_crc, bus.res_len, bus.res_err}, 0);
        do_reset();
        @(posedge clk);
        #2;
        frame_hex(32'h386, 3);
        load_frame(1, -1, 0);
        expect_res(1, 0, 2, 1'b0);
        wait_res("t5_done", 1, 30);
        chk("t5_clr_pulses", clr_cnt, 1);
        chk("t5_en_data", en_log.size() == 3 ? {en_log[0], en_log[1], en_log[2]} : 12'h0, 12'h386);
        // requester 3 arrives while requester 0 streams
        do_reset();
        @(posedge clk);
        #2;
        frame_hex(32'h11235, 5);
        load_frame(0, -1, 0);
        expect_res(0, 0, 4, 1'b0);
        for (int i = 0; i < 10 && !bus.req_ready[0]; i++) @(negedge clk);
        chk("t6_grant0", bus.req_ready[0], 1);
        frame_hex(32'hD, 1);
        load_frame(3, -1, 0);
        expect_res(3, 0, 0, 1'b0);
        n3 = 0;
        base = res_seen;
        for (int i = 0; i < 30 && res_seen == base; i++) begin
            @(negedge clk);
            if (bus.req_ready[3]) n3++;
        end
        chk("t6_ready3_during_0", n3, 0);
        wait_res("t6_done", 1, 30);
        chk("t6_spacing", res_cyc.size() == 2 ? res_cyc[1] - res_cyc[0] : -1, 5);
        chk("exp_drained_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
